adder_tree_seq: RTL and testbench
=================================

# adder_tree_seq

Sequencing controller for an external `adder_tree2n` instance. It streams multi-beat vector jobs through the tree, presenting one `A`/`B` pair per beat. Each beat's tree sum is accumulated into a wide running total, and one result per job is emitted with a valid/ready handshake. It sits between a vector producer and any consumer needing long dot-sum reductions wider than a single tree pass.

## Interface
- `TREE_SIZE`, 8, element pairs per beat (power of 2), matches the tree instance
- `DATA_SIZE`, 8, bits per element, matches the tree instance
- `MAX_BEATS`, 16, beats per job guaranteed without overflow (power of 2)
- Derived: `ZW = DATA_SIZE + $clog2(TREE_SIZE) + 1`; `ACC_W = ZW + $clog2(MAX_BEATS)`; `CW = $clog2(MAX_BEATS) + 1`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  beat present
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_last`  in  1  final beat of job, qualified by handshake
- `in_a`  in  `TREE_SIZE*DATA_SIZE`  A vector for the beat
- `in_b`  in  `TREE_SIZE*DATA_SIZE`  B vector for the beat
- `tree_a`  out  `TREE_SIZE*DATA_SIZE`  to tree `A`
- `tree_b`  out  `TREE_SIZE*DATA_SIZE`  to tree `B`
- `tree_z`  in  `ZW`  from tree `Z`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  `ACC_W`  job total, unsigned, modulo `2^ACC_W`
- `out_count`  out  `CW`  beats in job, saturating at `MAX_BEATS`
- `out_ovf`  out  1  job had more than `MAX_BEATS` beats

## Operation
- `tree_a`/`tree_b` are combinational pass-throughs of `in_a`/`in_b`. The tree is combinational; `tree_z` is used in the same cycle.
- FSM states:
  - `IDLE`: `in_ready=1`, accumulator and count zero. First handshake goes to `RUN`, or to `OUT` / `DRAIN` if `in_last`.
  - `RUN`: `in_ready=1`. Each handshake adds the beat sum and increments the count. Handshake with `in_last` goes to `OUT` (or to `DRAIN` when piped).
  - `DRAIN`: exists only with the pipe macro. `in_ready=0`; lasts one cycle while the final registered sum lands, then goes to `OUT`.
  - `OUT`: `in_ready=0`, `out_valid=1`. `out_sum`, `out_count` and `out_ovf` are held stable. When `out_ready=1`, go to `IDLE` and clear the accumulator, count and ovf.
- Arithmetic:
  - `acc <= acc + zero_extend(tree_z)`, all unsigned, wraps modulo `2^ACC_W`.
  - Count increments per beat up to `MAX_BEATS`, then holds.
  - `out_ovf` is set on any beat accepted while count already equals `MAX_BEATS`, and is sticky until the result is consumed.
- `in_valid=0` bubbles in `RUN` are legal: no state change, no accumulation.
- `in_a`, `in_b` and `in_last` are don't-care when not handshaken.

## Timing
- Reset values:
  - state `IDLE`; `in_ready=1`
  - `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`
  - pipe register and its valid bit are 0
- `rst_n` low at any point, including mid-job or in `OUT`, discards the partial job immediately.
- Without the macro: `out_valid` rises in the cycle after the last-beat handshake, so latency is 1 cycle.
- With the macro: latency is 2 cycles (`DRAIN` inserted).
- Throughput is 1 beat/cycle within a job. There is a minimum gap of 1 cycle (`OUT` with `out_ready=1` held) between jobs, or 2 cycles when piped.
- The result is not accepted and `IDLE` is not re-entered in the same cycle. A new job's first beat is accepted no earlier than the cycle after the `OUT` handshake.

## Configuration
- `ADDER_TREE_SEQ_PIPE_EN`
  - **Defined:** `tree_z` is captured in a `ZW`-bit register with a valid bit. The accumulator adds the registered value one cycle after the beat handshake. The `DRAIN` state is present, giving end-of-job latency 2. This cuts the tree-to-accumulator path.
  - **Undefined:** no pipe register, no `DRAIN`, latency 1.
- Sums, counts and ovf are identical in both builds.

## Test plan
All scenarios use `TREE_SIZE=4`, `DATA_SIZE=8`, `MAX_BEATS=4` (`ZW=11`, `ACC_W=13`, `CW=3`). Run scenarios 1–5 with and without `ADDER_TREE_SEQ_PIPE_EN`.

1. Single beat: all A elements `1`, all B elements `2`, `in_last=1` → `tree_z=12`; `out_valid` rises 1 cycle later (2 cycles piped) with `out_sum=12`, `out_count=1`, `out_ovf=0`.
2. Four back-to-back beats, all elements `0xFF` → `out_sum=8160`, `out_count=4`, `out_ovf=0`.
3. Five beats, all elements `0xFF` → `out_sum=2008` (10200 mod 8192), `out_count=4`, `out_ovf=1`.
4. Backpressure: result ready, `out_ready=0` for 3 cycles → outputs stable and `in_ready=0` throughout. After `out_ready=1`, `in_ready=1` the next cycle and all outputs are 0.
5. Bubbles: three beats of value 12 separated by 2-cycle `in_valid=0` gaps → `out_sum=36`, `out_count=3`.
6. Reset mid-job: two beats accepted, then `rst_n` low for 1 cycle → all outputs at reset values. A following single-beat job of 12 yields `out_sum=12`, `out_count=1`.

Source files
------------

// File: rtl/adder_tree_seq.sv
// adder_tree_seq: feeds multi-beat A/B vector jobs through an external combinational adder
// tree and accumulates one wide total per job. Optional macro: ADDER_TREE_SEQ_PIPE_EN.
module adder_tree_seq #(
  parameter int  TREE_SIZE = 8,
  parameter int  DATA_SIZE = 8,
  parameter int  MAX_BEATS = 16,
  localparam int ZW        = DATA_SIZE + $clog2(TREE_SIZE) + 1,
  localparam int ACC_W     = ZW + $clog2(MAX_BEATS),
  localparam int CW        = $clog2(MAX_BEATS) + 1,
  localparam int VW        = TREE_SIZE * DATA_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [VW-1:0]    in_a,
  input  logic [VW-1:0]    in_b,
  output logic [VW-1:0]    tree_a,
  output logic [VW-1:0]    tree_b,
  input  logic [ZW-1:0]    tree_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

`ifdef ADDER_TREE_SEQ_PIPE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OUT   = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             beat_hs_s;
  logic             cnt_max_s;
  logic [ACC_W-1:0] addend_s;
  state_e           last_st_s;

  assign tree_a    = in_a;
  assign tree_b    = in_b;
  assign beat_hs_s = in_valid & in_ready_q;
  assign cnt_max_s = (cnt_q == CW'(MAX_BEATS));

`ifdef ADDER_TREE_SEQ_PIPE_EN
  logic [ZW-1:0] pipe_q, pipe_d;
  logic          pipe_vld_q, pipe_vld_d;

  // Capture the tree sum of each accepted beat; it lands in the accumulator a cycle later.
  always_comb begin
    pipe_d     = pipe_q;
    pipe_vld_d = 1'b0;
    if (beat_hs_s) begin
      pipe_d     = tree_z;
      pipe_vld_d = 1'b1;
    end else begin
      pipe_d     = pipe_q;
      pipe_vld_d = 1'b0;
    end
  end

  // Pipe register and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q     <= {ZW{1'b0}};
      pipe_vld_q <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  assign addend_s  = pipe_vld_q ? ACC_W'(pipe_q) : {ACC_W{1'b0}};
  assign last_st_s = ST_DRAIN;
`else
  assign addend_s  = beat_hs_s ? ACC_W'(tree_z) : {ACC_W{1'b0}};
  assign last_st_s = ST_OUT;
`endif

  // Next-state, accumulate, beat count and overflow tracking.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q + addend_s;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (beat_hs_s) begin
          // Count saturates; a beat beyond the guaranteed depth flags overflow.
          if (cnt_max_s) begin
            cnt_d = cnt_q;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1'b1);
            ovf_d = ovf_q;
          end
          state_d = in_last ? last_st_s : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
`ifdef ADDER_TREE_SEQ_PIPE_EN
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
`endif
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {CW{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {CW{1'b0}};
        ovf_d   = 1'b0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
    out_valid_d = (state_d == ST_OUT);
  end

  // State, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_tree_seq.sv
// Directed, table-driven bench for adder_tree_seq with a behavioural model of the adder tree.
module tb_adder_tree_seq;
  localparam int TS = 4;
  localparam int DS = 8;
  localparam int MB = 4;
  localparam int ZW = 11;
  localparam int AW = 13;
  localparam int CW = 3;
  localparam int VW = TS * DS;
`ifdef ADDER_TREE_SEQ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int       nbeats;
    logic [7:0] a;
    logic [7:0] b;
    int       gap;
    int       hold;
    int       exp_sum;
    int       exp_cnt;
    int       exp_ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic [VW-1:0] tree_a;
  logic [VW-1:0] tree_b;
  logic [ZW-1:0] tree_z;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int checks = 0;
  int failures = 0;
  vec_t vecs[6];

  adder_tree_seq #(.TREE_SIZE(TS), .DATA_SIZE(DS), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .tree_a(tree_a), .tree_b(tree_b), .tree_z(tree_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Reference adder tree: sum of every A and B element.
  always_comb begin
    tree_z = '0;
    for (int i = 0; i < TS; i++) begin
      tree_z = tree_z + ZW'(tree_a[i*DS +: DS]) + ZW'(tree_b[i*DS +: DS]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic last, input string nm);
    in_valid = 1'b1;
    in_a     = {TS{a}};
    in_b     = {TS{b}};
    in_last  = last;
    chk({nm, ".in_ready"}, int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_last  = 1'($urandom_range(1, 0));
  endtask

  task automatic run_job(input vec_t v, input string nm);
    int lat;
    int held;
    for (int i = 0; i < v.nbeats; i++) begin
      drive_beat(v.a, v.b, (i == v.nbeats - 1), nm);
      if (i != v.nbeats - 1) begin
        for (int g = 0; g < v.gap; g++) step();
      end
    end
    lat = 1;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    chk({nm, ".latency"}, lat, LAT);
    chk({nm, ".sum"}, int'(out_sum), v.exp_sum);
    chk({nm, ".count"}, int'(out_count), v.exp_cnt);
    chk({nm, ".ovf"}, int'(out_ovf), v.exp_ovf);
    chk({nm, ".in_ready_out"}, int'(in_ready), 0);
    held = int'(out_sum);
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk({nm, ".hold_valid"}, int'(out_valid), 1);
      chk({nm, ".hold_in_ready"}, int'(in_ready), 0);
      chk({nm, ".hold_sum"}, int'(out_sum), held);
      chk({nm, ".hold_count"}, int'(out_count), v.exp_cnt);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, ".done_valid"}, int'(out_valid), 0);
    chk({nm, ".done_in_ready"}, int'(in_ready), 1);
    chk({nm, ".done_sum"}, int'(out_sum), 0);
    chk({nm, ".done_count"}, int'(out_count), 0);
    chk({nm, ".done_ovf"}, int'(out_ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    //              beats  a      b      gap hold sum   cnt ovf
    vecs[0] = '{1, 8'h01, 8'h02, 0, 3, 12,   1, 0};
    vecs[1] = '{4, 8'hFF, 8'hFF, 0, 0, 8160, 4, 0};
    vecs[2] = '{5, 8'hFF, 8'hFF, 0, 1, 2008, 4, 1};
    vecs[3] = '{3, 8'h01, 8'h02, 2, 0, 36,   3, 0};
    vecs[4] = '{2, 8'h03, 8'h04, 1, 2, 56,   2, 0};
    vecs[5] = '{4, 8'h80, 8'h10, 0, 0, 2304, 4, 0};

    step();
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.sum", int'(out_sum), 0);
    chk("reset.count", int'(out_count), 0);
    chk("reset.ovf", int'(out_ovf), 0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k], $sformatf("job%0d", k));
    end

    // Reset in the middle of a job discards the partial total.
    drive_beat(8'h01, 8'h02, 1'b0, "midrst.b0");
    drive_beat(8'h01, 8'h02, 1'b0, "midrst.b1");
    chk("midrst.partial_count", int'(out_count), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", int'(in_ready), 1);
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.sum", int'(out_sum), 0);
    chk("midrst.count", int'(out_count), 0);
    chk("midrst.ovf", int'(out_ovf), 0);
    step();
    rst_n = 1'b1;
    step();
    run_job(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
